// File: rtl/spongent_pi_if.sv
// Spongent bit-permutation index bus.
//   in  : source bit index j, driven by the master
//   out : registered permuted index P(j), driven by the slave (spongent_pi)
// Modports:
//   master : drives in, observes out
//   slave  : observes in, drives out
interface spongent_pi_if #(
    parameter int W = 9
);
    logic [W-1:0] in;
    logic [W-1:0] out;

    modport master (output in, input out);
    modport slave  (input in, output out);
endinterface

// File: rtl/spongent_pi.sv
// Spongent pLayer index generator: maps state bit position j to
//   P(j) = (j*NB/4) mod (NB-1)  for j < NB-1
//   P(NB-1) = NB-1
// The result is registered, so there is one cycle of latency.
// There is no enable and no handshake; the block runs on every clock.
// Ports:
//   clk      : clock, rising edge
//   rst      : asynchronous reset, active-high; clears out to 0
//   bus.in   : source index j (W bits)
//   bus.out  : registered P(j) (W bits)
// Build option:
//   SPONGENT_PI_RANGE_CHECK_EN
//     defined   : in >= NB produces out = all-ones as an invalid-index flag
//     undefined : in >= NB is passed through the same multiply/modulo datapath
module spongent_pi #(
    parameter int NB = 264,
    parameter int W  = 9
) (
    input  logic          clk,
    input  logic          rst,
    spongent_pi_if.slave  bus
);
    // The product width leaves room for the largest W-bit index times NB/4.
    localparam int            PW      = W + $clog2(NB / 4) + 1;
    localparam logic [PW-1:0] MULT    = PW'(NB / 4);
    localparam logic [PW-1:0] MODV    = PW'(NB - 1);
`ifdef SPONGENT_PI_RANGE_CHECK_EN
    localparam logic [PW-1:0] NB_FULL = PW'(NB);
`endif

    logic [PW-1:0] in_ext;
    logic [PW-1:0] prod;
    logic [PW-1:0] rem;
    logic [W-1:0]  p_next;

    always_comb begin
        in_ext = PW'(bus.in);
        prod   = in_ext * MULT;
        // The divisor is a constant, so this reduces to combinational logic.
        rem    = prod % MODV;
        p_next = W'(rem);
        // The last bit is a fixed point; the formula alone would give 0.
        if (in_ext == MODV) begin
            p_next = W'(MODV);
        end
`ifdef SPONGENT_PI_RANGE_CHECK_EN
        if (in_ext >= NB_FULL) begin
            p_next = '1;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.out <= '0;
        end else begin
            bus.out <= p_next;
        end
    end
endmodule

// File: tb/tb_spongent_pi.sv
module tb_spongent_pi;
    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    logic seen [0:263];

    spongent_pi_if #(.W(9)) bus ();

    spongent_pi #(.NB(264), .W(9)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    initial begin
        logic [8:0] obs;
        logic [8:0] zero9;
        logic [8:0] exp9;
        int         inv;
        int         dup;
        int         e;

        zero9 = '0;
        for (int k = 0; k < 264; k++) seen[k] = 1'b0;

        // reset held with a nonzero input
        rst    = 1'b1;
        bus.in = 9'd5;
        repeat (3) step();
        check("reset_hold", bus.out, 9'd0);
        #3 rst = 1'b0;
        step();
        check("first_after_reset", bus.out, 9'd67);

        // consecutive inputs, one cycle latency each
        bus.in = 9'd1; step(); check("in1", bus.out, 9'd66);
        bus.in = 9'd2; step(); check("in2", bus.out, 9'd132);
        bus.in = 9'd3; step(); check("in3", bus.out, 9'd198);
        bus.in = 9'd4; step(); check("in4", bus.out, 9'd1);
        bus.in = 9'd8; step(); check("in8", bus.out, 9'd2);

        // boundaries and fixed points
        bus.in = 9'd0;   step(); check("in0",   bus.out, 9'd0);
        bus.in = 9'd262; step(); check("in262", bus.out, 9'd197);
        bus.in = 9'd263; step(); check("in263", bus.out, 9'd263);
        bus.in = 9'd100; step(); check("in100", bus.out, 9'd25);

        // stability with constant input
        step(); check("in100_stable", bus.out, 9'd25);

        // full sweep: bijective and inverse relation
        for (int j = 0; j < 264; j++) begin
            bus.in = 9'(j);
            step();
            obs = bus.out;
            e   = (j == 263) ? 263 : (j * 66) % 263;
            exp9 = 9'(e);
            check("sweep_value", obs, exp9);
            if (j < 263) begin
                inv = (4 * int'(obs)) % 263;
                check("sweep_inverse", 9'(inv), 9'(j));
            end
            if (obs < 9'd264) begin
                dup = seen[obs] ? 1 : 0;
                seen[obs] = 1'b1;
            end else begin
                dup = 1;
            end
            check("sweep_distinct", 9'(dup), zero9);
        end

        // asynchronous reset between edges
        bus.in = 9'd3;
        step();
        check("pre_async", bus.out, 9'd198);
        #2 rst = 1'b1;
        #1 check("async_clear", bus.out, 9'd0);
        step();
        check("async_held", bus.out, 9'd0);
        #2 rst = 1'b0;
        step();
        check("async_release", bus.out, 9'd198);

        // out-of-range index
        bus.in = 9'd300;
        step();
`ifdef SPONGENT_PI_RANGE_CHECK_EN
        check("in300_flag", bus.out, 9'd511);
`else
        check("in300_wrap", bus.out, 9'd75);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
